// File: rtl/rv_bus_arbiter.sv
// rv_bus_arbiter: shares one single-port memory bus between the instruction
// fetch port and the load/store data port of the RV core. Data requests win
// by default; fetch is forced through after DATA_PRIO_MAX back-to-back data
// grants. One transaction is outstanding at a time. A hung transaction is
// aborted after TIMEOUT busy cycles and acked with err=1.
//
// Ports
//   i_clk, i_reset_n               clock, synchronous active-low reset
//   i_ifetch_req/addr              fetch request (word address [31:2])
//   o_ifetch_ack/err/data          fetch completion pulse, timeout flag, word
//   i_dmem_req/we/addr/sel/wdata   data request (byte address, lanes, store data)
//   o_dmem_ack/err/rdata           data completion pulse, timeout flag, load data
//   o_bus_req/we/addr/sel/wdata    downstream request, held until i_bus_ack
//   i_bus_ack, i_bus_rdata         downstream single-cycle completion and data
module rv_bus_arbiter #(
    parameter int unsigned DATA_PRIO_MAX = 4,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ifetch_req,
    input  logic [29:0] i_ifetch_addr,
    output logic        o_ifetch_ack,
    output logic        o_ifetch_err,
    output logic [31:0] o_ifetch_data,
    input  logic        i_dmem_req,
    input  logic        i_dmem_we,
    input  logic [31:0] i_dmem_addr,
    input  logic [3:0]  i_dmem_sel,
    input  logic [31:0] i_dmem_wdata,
    output logic        o_dmem_ack,
    output logic        o_dmem_err,
    output logic [31:0] o_dmem_rdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_sel,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam int unsigned STREAK_W = $clog2(DATA_PRIO_MAX + 1);
    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state;
    logic                owner_data;
    logic [STREAK_W-1:0] streak;
    logic [CNT_W-1:0]    tmo_cnt;

    logic fetch_wins_c;
    logic streak_max_c;
    logic timeout_hit_c;

    // Fetch wins when it is alone or data has used up its consecutive-grant budget.
    assign streak_max_c  = (streak == STREAK_W'(DATA_PRIO_MAX));
    assign fetch_wins_c  = i_ifetch_req && (!i_dmem_req || streak_max_c);
    assign timeout_hit_c = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // Arbitration / transaction FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state         <= S_IDLE;
            owner_data    <= 1'b0;
            streak        <= '0;
            tmo_cnt       <= '0;
            o_bus_req     <= 1'b0;
            o_bus_we      <= 1'b0;
            o_bus_addr    <= '0;
            o_bus_sel     <= '0;
            o_bus_wdata   <= '0;
            o_ifetch_ack  <= 1'b0;
            o_ifetch_err  <= 1'b0;
            o_ifetch_data <= '0;
            o_dmem_ack    <= 1'b0;
            o_dmem_err    <= 1'b0;
            o_dmem_rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!i_ifetch_req) begin
                        streak <= '0;
                    end
                    if (fetch_wins_c) begin
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= 1'b0;
                        o_bus_addr  <= {i_ifetch_addr, 2'b00};
                        o_bus_sel   <= 4'hF;
                        o_bus_wdata <= '0;
                        owner_data  <= 1'b0;
                        streak      <= '0;
                        tmo_cnt     <= '0;
                        state       <= S_BUSY;
                    end else if (i_dmem_req) begin
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_dmem_we;
                        o_bus_addr  <= i_dmem_addr;
                        o_bus_sel   <= i_dmem_sel;
                        o_bus_wdata <= i_dmem_wdata;
                        owner_data  <= 1'b1;
                        tmo_cnt     <= '0;
                        // Only count data grants that actually made fetch wait.
                        if (i_ifetch_req && !streak_max_c) begin
                            streak <= streak + STREAK_W'(1);
                        end
                        state <= S_BUSY;
                    end
                end

                S_BUSY: begin
                    // Ack takes precedence over a timeout landing on the same cycle.
                    if (i_bus_ack) begin
                        o_bus_req <= 1'b0;
                        if (owner_data) begin
                            o_dmem_ack   <= 1'b1;
                            o_dmem_err   <= 1'b0;
                            o_dmem_rdata <= o_bus_we ? 32'd0 : i_bus_rdata;
                        end else begin
                            o_ifetch_ack  <= 1'b1;
                            o_ifetch_err  <= 1'b0;
                            o_ifetch_data <= i_bus_rdata;
                        end
                        state <= S_RESP;
                    end else if (timeout_hit_c) begin
                        o_bus_req <= 1'b0;
                        if (owner_data) begin
                            o_dmem_ack   <= 1'b1;
                            o_dmem_err   <= 1'b1;
                            o_dmem_rdata <= '0;
                        end else begin
                            o_ifetch_ack  <= 1'b1;
                            o_ifetch_err  <= 1'b1;
                            o_ifetch_data <= '0;
                        end
                        state <= S_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    // Single-cycle ack pulse; requester drops or renews meanwhile.
                    o_ifetch_ack <= 1'b0;
                    o_ifetch_err <= 1'b0;
                    o_dmem_ack   <= 1'b0;
                    o_dmem_err   <= 1'b0;
                    state        <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_bus_arbiter.sv
// Directed self-checking bench for rv_bus_arbiter (DATA_PRIO_MAX=4, TIMEOUT=8).
module tb_rv_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ifetch_req;
    logic [29:0] ifetch_addr;
    logic        ifetch_ack;
    logic        ifetch_err;
    logic [31:0] ifetch_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_sel;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic        dmem_err;
    logic [31:0] dmem_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rv_bus_arbiter #(
        .DATA_PRIO_MAX(4),
        .TIMEOUT(8)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_ifetch_req (ifetch_req),
        .i_ifetch_addr(ifetch_addr),
        .o_ifetch_ack (ifetch_ack),
        .o_ifetch_err (ifetch_err),
        .o_ifetch_data(ifetch_data),
        .i_dmem_req   (dmem_req),
        .i_dmem_we    (dmem_we),
        .i_dmem_addr  (dmem_addr),
        .i_dmem_sel   (dmem_sel),
        .i_dmem_wdata (dmem_wdata),
        .o_dmem_ack   (dmem_ack),
        .o_dmem_err   (dmem_err),
        .o_dmem_rdata (dmem_rdata),
        .o_bus_req    (bus_req),
        .o_bus_we     (bus_we),
        .o_bus_addr   (bus_addr),
        .o_bus_sel    (bus_sel),
        .o_bus_wdata  (bus_wdata),
        .i_bus_ack    (bus_ack),
        .i_bus_rdata  (bus_rdata)
    );

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until o_bus_req rises or the budget runs out.
    task automatic wait_grant(output bit ok);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus_req && n < 10);
        ok = bus_req;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        total++;
        if ({bus_req, bus_we, bus_addr, bus_sel, bus_wdata} !== 70'd0)
            $display("FAIL reset_bus: got req=%b we=%b addr=%h sel=%h wdata=%h exp all 0",
                     bus_req, bus_we, bus_addr, bus_sel, bus_wdata);
        else passed++;
        total++;
        if ({ifetch_ack, ifetch_err, ifetch_data, dmem_ack, dmem_err, dmem_rdata} !== 68'd0)
            $display("FAIL reset_resp: got iack=%b ierr=%b idata=%h dack=%b derr=%b drdata=%h exp all 0",
                     ifetch_ack, ifetch_err, ifetch_data, dmem_ack, dmem_err, dmem_rdata);
        else passed++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch_only();
        int req_cycles = 0;
        ifetch_req  = 1'b1;
        ifetch_addr = 30'h10;
        tick();
        total++;
        if ({bus_req, bus_we, bus_addr, bus_sel} !== {1'b1, 1'b0, 32'h40, 4'hF})
            $display("FAIL fetch_grant: got req=%b we=%b addr=%h sel=%h exp 1 0 00000040 f",
                     bus_req, bus_we, bus_addr, bus_sel);
        else passed++;
        if (bus_req) req_cycles++;
        tick();
        if (bus_req) req_cycles++;
        tick();
        if (bus_req) req_cycles++;
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_0013;
        tick();
        if (bus_req) req_cycles++;
        bus_ack    = 1'b0;
        ifetch_req = 1'b0;
        total++;
        if ({ifetch_ack, ifetch_err, ifetch_data, dmem_ack} !== {1'b1, 1'b0, 32'h0000_0013, 1'b0})
            $display("FAIL fetch_ack: got ack=%b err=%b data=%h dack=%b exp 1 0 00000013 0",
                     ifetch_ack, ifetch_err, ifetch_data, dmem_ack);
        else passed++;
        total++;
        if (req_cycles !== 3)
            $display("FAIL fetch_req_len: got %0d exp 3", req_cycles);
        else passed++;
        tick();
        total++;
        if ({ifetch_ack, ifetch_data} !== {1'b0, 32'h0000_0013})
            $display("FAIL fetch_ack_pulse: got ack=%b data=%h exp 0 00000013", ifetch_ack, ifetch_data);
        else passed++;
        tick();
    endtask

    task automatic test_store_then_fetch();
        ifetch_req  = 1'b1;
        ifetch_addr = 30'h20;
        dmem_req    = 1'b1;
        dmem_we     = 1'b1;
        dmem_addr   = 32'h1000;
        dmem_sel    = 4'h3;
        dmem_wdata  = 32'hBEEF;
        tick();
        total++;
        if ({bus_req, bus_we, bus_addr, bus_sel, bus_wdata} !== {1'b1, 1'b1, 32'h1000, 4'h3, 32'hBEEF})
            $display("FAIL store_grant: got req=%b we=%b addr=%h sel=%h wdata=%h exp 1 1 00001000 3 0000beef",
                     bus_req, bus_we, bus_addr, bus_sel, bus_wdata);
        else passed++;
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_DEAD;
        tick();
        bus_ack  = 1'b0;
        dmem_req = 1'b0;
        total++;
        if ({dmem_ack, dmem_err, dmem_rdata, ifetch_ack} !== {1'b1, 1'b0, 32'h0, 1'b0})
            $display("FAIL store_ack: got ack=%b err=%b rdata=%h iack=%b exp 1 0 00000000 0",
                     dmem_ack, dmem_err, dmem_rdata, ifetch_ack);
        else passed++;
        tick();
        total++;
        if (bus_req !== 1'b0)
            $display("FAIL resp_no_arb: got req=%b exp 0", bus_req);
        else passed++;
        tick();
        total++;
        if ({bus_req, bus_we, bus_addr, bus_sel} !== {1'b1, 1'b0, 32'h80, 4'hF})
            $display("FAIL fetch_after_store: got req=%b we=%b addr=%h sel=%h exp 1 0 00000080 f",
                     bus_req, bus_we, bus_addr, bus_sel);
        else passed++;
        bus_ack   = 1'b1;
        bus_rdata = 32'h1234_5678;
        tick();
        bus_ack    = 1'b0;
        ifetch_req = 1'b0;
        total++;
        if ({ifetch_ack, ifetch_data, dmem_ack} !== {1'b1, 32'h1234_5678, 1'b0})
            $display("FAIL fetch2_ack: got ack=%b data=%h dack=%b exp 1 12345678 0",
                     ifetch_ack, ifetch_data, dmem_ack);
        else passed++;
        tick();
        tick();
    endtask

    task automatic test_data_priority();
        bit          ok;
        bit          exp_fetch [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_addr;
        ifetch_req  = 1'b1;
        ifetch_addr = 30'h30;
        dmem_req    = 1'b1;
        dmem_we     = 1'b0;
        dmem_addr   = 32'h2000;
        dmem_sel    = 4'hF;
        dmem_wdata  = 32'h0;
        for (int k = 0; k < 6; k++) begin
            wait_grant(ok);
            exp_addr = exp_fetch[k] ? 32'hC0 : 32'h2000;
            total++;
            if (!ok || bus_addr !== exp_addr)
                $display("FAIL prio_grant%0d: got req=%b addr=%h exp 1 %h", k, bus_req, bus_addr, exp_addr);
            else passed++;
            bus_ack   = 1'b1;
            bus_rdata = 32'hA0 + 32'(k);
            tick();
            bus_ack = 1'b0;
            total++;
            if (exp_fetch[k]) begin
                if ({ifetch_ack, dmem_ack, ifetch_data} !== {1'b1, 1'b0, 32'hA0 + 32'(k)})
                    $display("FAIL prio_ack%0d: got iack=%b dack=%b data=%h exp 1 0 %h",
                             k, ifetch_ack, dmem_ack, ifetch_data, 32'hA0 + 32'(k));
                else passed++;
                ifetch_req = 1'b0;
            end else begin
                if ({dmem_ack, ifetch_ack, dmem_rdata} !== {1'b1, 1'b0, 32'hA0 + 32'(k)})
                    $display("FAIL prio_ack%0d: got dack=%b iack=%b rdata=%h exp 1 0 %h",
                             k, dmem_ack, ifetch_ack, dmem_rdata, 32'hA0 + 32'(k));
                else passed++;
            end
        end
        dmem_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int req_cycles;
        dmem_req  = 1'b1;
        dmem_we   = 1'b0;
        dmem_addr = 32'h3000;
        wait_grant(ok);
        req_cycles = 0;
        while (bus_req && req_cycles < 20) begin
            req_cycles++;
            tick();
        end
        dmem_req = 1'b0;
        total++;
        if (!ok || req_cycles !== 8)
            $display("FAIL timeout_len: got %0d cycles exp 8", req_cycles);
        else passed++;
        total++;
        if ({dmem_ack, dmem_err, dmem_rdata, ifetch_ack} !== {1'b1, 1'b1, 32'h0, 1'b0})
            $display("FAIL timeout_ack: got ack=%b err=%b rdata=%h iack=%b exp 1 1 00000000 0",
                     dmem_ack, dmem_err, dmem_rdata, ifetch_ack);
        else passed++;
        tick();
        total++;
        if ({dmem_ack, dmem_err} !== 2'b00)
            $display("FAIL timeout_clear: got ack=%b err=%b exp 0 0", dmem_ack, dmem_err);
        else passed++;
        // Next grant after an abort behaves normally.
        dmem_req  = 1'b1;
        dmem_addr = 32'h3004;
        wait_grant(ok);
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_ack  = 1'b0;
        dmem_req = 1'b0;
        total++;
        if (!ok || {dmem_ack, dmem_err, dmem_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D})
            $display("FAIL after_timeout: got ack=%b err=%b rdata=%h exp 1 0 cafef00d",
                     dmem_ack, dmem_err, dmem_rdata);
        else passed++;
        tick();
        // Fetch side abort as well.
        ifetch_req  = 1'b1;
        ifetch_addr = 30'h44;
        wait_grant(ok);
        req_cycles = 0;
        while (bus_req && req_cycles < 20) begin
            req_cycles++;
            tick();
        end
        ifetch_req = 1'b0;
        total++;
        if (!ok || {ifetch_ack, ifetch_err, ifetch_data, dmem_ack} !== {1'b1, 1'b1, 32'h0, 1'b0} || req_cycles !== 8)
            $display("FAIL fetch_timeout: got ack=%b err=%b data=%h dack=%b cycles=%0d exp 1 1 00000000 0 8",
                     ifetch_ack, ifetch_err, ifetch_data, dmem_ack, req_cycles);
        else passed++;
        tick();
        tick();
    endtask

    task automatic test_reset_busy();
        bit ok;
        dmem_req  = 1'b1;
        dmem_we   = 1'b0;
        dmem_addr = 32'h4000;
        wait_grant(ok);
        tick();
        reset_n = 1'b0;
        tick();
        total++;
        if (!ok || {bus_req, dmem_ack, ifetch_ack} !== 3'b000)
            $display("FAIL reset_busy: got req=%b dack=%b iack=%b exp 0 0 0", bus_req, dmem_ack, ifetch_ack);
        else passed++;
        reset_n   = 1'b1;
        dmem_req  = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h5555_AAAA;
        tick();
        bus_ack = 1'b0;
        total++;
        if ({bus_req, dmem_ack, ifetch_ack, dmem_rdata} !== {3'b000, 32'h0})
            $display("FAIL late_ack: got req=%b dack=%b iack=%b rdata=%h exp 0 0 0 00000000",
                     bus_req, dmem_ack, ifetch_ack, dmem_rdata);
        else passed++;
        tick();
        total++;
        if ({dmem_ack, ifetch_ack} !== 2'b00)
            $display("FAIL late_ack2: got dack=%b iack=%b exp 0 0", dmem_ack, ifetch_ack);
        else passed++;
    endtask

    task automatic test_ack_on_timeout();
        bit ok;
        int held = 0;
        dmem_req  = 1'b1;
        dmem_we   = 1'b0;
        dmem_addr = 32'h5000;
        wait_grant(ok);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus_req) held++;
        end
        total++;
        if (!ok || held !== 7)
            $display("FAIL pre_timeout_hold: got %0d exp 7", held);
        else passed++;
        bus_ack   = 1'b1;
        bus_rdata = 32'h600D_D00D;
        tick();
        bus_ack  = 1'b0;
        dmem_req = 1'b0;
        total++;
        if ({bus_req, dmem_ack, dmem_err, dmem_rdata} !== {1'b0, 1'b1, 1'b0, 32'h600D_D00D})
            $display("FAIL ack_vs_timeout: got req=%b ack=%b err=%b rdata=%h exp 0 1 0 600dd00d",
                     bus_req, dmem_ack, dmem_err, dmem_rdata);
        else passed++;
        tick();
        bus_ack   = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
        tick();
        bus_ack = 1'b0;
        total++;
        if ({bus_req, dmem_ack, ifetch_ack, dmem_rdata} !== {3'b000, 32'h600D_D00D})
            $display("FAIL stray_ack: got req=%b dack=%b iack=%b rdata=%h exp 0 0 0 600dd00d",
                     bus_req, dmem_ack, ifetch_ack, dmem_rdata);
        else passed++;
        tick();
    endtask

    initial begin
        reset_n     = 1'b0;
        ifetch_req  = 1'b0;
        ifetch_addr = '0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = '0;
        dmem_sel    = '0;
        dmem_wdata  = '0;
        bus_ack     = 1'b0;
        bus_rdata   = '0;
        test_reset();
        test_fetch_only();
        test_store_then_fetch();
        test_data_priority();
        test_timeout();
        test_reset_busy();
        test_ack_on_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion exp finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
